// File: rtl/defuzz_wavg.sv
// Singleton weighted-average defuzzifier: one shared MAC over nine rules,
// then a fixed-latency 36-step restoring divide of |num| by den.
module defuzz_wavg #(
   parameter logic [143:0] RULE_C = {
      16'sd20000, 16'sd10000, 16'sd0,
      16'sd10000, 16'sd0, -16'sd10000,
      16'sd0, -16'sd10000, -16'sd20000
   },
   parameter logic signed [15:0] DEFAULT_Y = 16'sd0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [15:0]        w00,
   input  logic [15:0]        w01,
   input  logic [15:0]        w02,
   input  logic [15:0]        w10,
   input  logic [15:0]        w11,
   input  logic [15:0]        w12,
   input  logic [15:0]        w20,
   input  logic [15:0]        w21,
   input  logic [15:0]        w22,
   output logic               out_valid,
   input  logic               out_ready,
   output logic signed [15:0] y,
   output logic               zero_w,
   output logic               busy
);

   typedef enum logic [1:0] {S_IDLE, S_ACC, S_DIV, S_OUT} state_t;

   state_t             state_q, state_d;
   logic [15:0]        w_q [9];
   logic [15:0]        w_d [9];
   logic [3:0]         k_q, k_d;
   logic [5:0]         cnt_q, cnt_d;
   logic signed [35:0] num_q, num_d;
   logic [19:0]        den_q, den_d;
   logic [35:0]        dvd_q, dvd_d;
   logic [20:0]        rem_q, rem_d;
   logic               neg_q, neg_d;
   logic signed [15:0] y_q, y_d;
   logic               zero_w_q, zero_w_d;

   logic signed [15:0] c_tab [9];
   logic [15:0]        w_sel;
   logic signed [15:0] c_sel;
   logic signed [32:0] prod;
   logic signed [35:0] num_acc;
   logic [19:0]        den_acc;
   logic [35:0]        num_mag;
   logic [21:0]        rem_sh;
   logic [20:0]        rem_sub;
   logic               qbit;
   logic [35:0]        quo_nxt;
   logic [15:0]        q_mag;

   for (genvar g = 0; g < 9; g++) begin : g_ctab
      assign c_tab[g] = RULE_C[16*g +: 16];
   end

   // Single shared 17x16 signed multiplier, indexed by rule counter
   always_comb begin
      w_sel   = w_q[k_q];
      c_sel   = c_tab[k_q];
      prod    = $signed({1'b0, w_sel}) * c_sel;
      num_acc = num_q + {{3{prod[32]}}, prod};
      den_acc = den_q + {4'b0000, w_sel};
      num_mag = num_acc[35] ? -num_acc : num_acc;
      rem_sh  = {rem_q, dvd_q[35]};
      qbit    = rem_sh >= {2'b00, den_q};
      rem_sub = rem_sh[20:0] - {1'b0, den_q};
      quo_nxt = {dvd_q[34:0], qbit};
      q_mag   = quo_nxt[15:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         for (int i = 0; i < 9; i++) w_q[i] <= '0;
         k_q      <= '0;
         cnt_q    <= '0;
         num_q    <= '0;
         den_q    <= '0;
         dvd_q    <= '0;
         rem_q    <= '0;
         neg_q    <= 1'b0;
         y_q      <= '0;
         zero_w_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         for (int i = 0; i < 9; i++) w_q[i] <= w_d[i];
         k_q      <= k_d;
         cnt_q    <= cnt_d;
         num_q    <= num_d;
         den_q    <= den_d;
         dvd_q    <= dvd_d;
         rem_q    <= rem_d;
         neg_q    <= neg_d;
         y_q      <= y_d;
         zero_w_q <= zero_w_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (in_valid)         state_d = S_ACC;
         S_ACC:  if (k_q == 4'd8)      state_d = S_DIV;
         S_DIV:  if (cnt_q == 6'd35)   state_d = S_OUT;
         S_OUT:  if (out_ready)        state_d = S_IDLE;
      endcase
   end

   always_comb begin
      for (int i = 0; i < 9; i++) w_d[i] = w_q[i];
      k_d      = k_q;
      cnt_d    = cnt_q;
      num_d    = num_q;
      den_d    = den_q;
      dvd_d    = dvd_q;
      rem_d    = rem_q;
      neg_d    = neg_q;
      y_d      = y_q;
      zero_w_d = zero_w_q;
      unique case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               w_d[0] = w00; w_d[1] = w01; w_d[2] = w02;
               w_d[3] = w10; w_d[4] = w11; w_d[5] = w12;
               w_d[6] = w20; w_d[7] = w21; w_d[8] = w22;
               num_d  = '0;
               den_d  = '0;
               k_d    = '0;
            end
         end
         S_ACC: begin
            num_d = num_acc;
            den_d = den_acc;
            k_d   = k_q + 4'd1;
            if (k_q == 4'd8) begin
               dvd_d = num_mag;
               neg_d = num_acc[35];
               rem_d = '0;
               cnt_d = '0;
            end
         end
         S_DIV: begin
            // den==0 runs the full divide anyway to keep latency fixed
            rem_d = qbit ? rem_sub : rem_sh[20:0];
            dvd_d = quo_nxt;
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'd35) begin
               zero_w_d = (den_q == '0);
               if (den_q == '0) y_d = DEFAULT_Y;
               else if (neg_q)  y_d = -$signed(q_mag);
               else             y_d = $signed(q_mag);
            end
         end
         S_OUT: ;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == S_IDLE);
      out_valid = (state_q == S_OUT);
      busy      = (state_q == S_ACC) || (state_q == S_DIV);
      y         = y_q;
      zero_w    = zero_w_q;
   end

endmodule

// File: tb/tb_defuzz_wavg.sv
// Bench for defuzz_wavg: directed vector table, handshake/reset sequences,
// and random weight sets against an arithmetic reference model.
module tb_defuzz_wavg;

   typedef logic [8:0][15:0] wset_t;
   typedef struct {
      wset_t              w;
      logic signed [15:0] y;
      logic               zw;
      string              nm;
   } vec_t;

   logic               clk = 1'b0;
   logic               rst;
   logic               in_valid;
   logic               in_ready;
   logic [15:0]        w00, w01, w02, w10, w11, w12, w20, w21, w22;
   logic               out_valid;
   logic               out_ready;
   logic signed [15:0] y;
   logic               zero_w;
   logic               busy;

   int total = 0;
   int bad   = 0;

   const int rc [9] = '{-20000, -10000, 0, -10000, 0, 10000, 0, 10000, 20000};

   defuzz_wavg dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .w00(w00), .w01(w01), .w02(w02),
      .w10(w10), .w11(w11), .w12(w12),
      .w20(w20), .w21(w21), .w22(w22),
      .out_valid(out_valid), .out_ready(out_ready),
      .y(y), .zero_w(zero_w), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic wset_t wv(input int ka, input logic [15:0] va,
                                input int kb, input logic [15:0] vb);
      wset_t r;
      r = '0;
      if (ka >= 0) r[ka] = va;
      if (kb >= 0) r[kb] = vb;
      return r;
   endfunction

   task automatic model(input wset_t w, output logic signed [15:0] ey,
                        output logic ezw);
      longint num, den;
      num = 0;
      den = 0;
      for (int k = 0; k < 9; k++) begin
         num += longint'(w[k]) * longint'(rc[k]);
         den += longint'(w[k]);
      end
      ezw = (den == 0);
      ey  = (den == 0) ? 16'sd0 : 16'(num / den);
   endtask

   task automatic set_w(input wset_t w);
      w00 = w[0]; w01 = w[1]; w02 = w[2];
      w10 = w[3]; w11 = w[4]; w12 = w[5];
      w20 = w[6]; w21 = w[7]; w22 = w[8];
   endtask

   task automatic do_op(input wset_t w, input logic signed [15:0] ey,
                        input logic ezw, input string nm);
      int n;
      logic signed [15:0] yprev;
      n = 0;
      while (!in_ready && n < 200) begin
         @(posedge clk); #1; n++;
      end
      chk({nm, " in_ready"}, in_ready, 1);
      yprev = y;
      set_w(w);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      set_w(wset_t'({$urandom, $urandom, $urandom, $urandom, $urandom}));
      n = 0;
      while (!out_valid && n < 100) begin
         if (n == 20) begin
            chk({nm, " y_hold"}, y, yprev);
            chk({nm, " busy"}, busy, 1);
         end
         @(posedge clk); #1; n++;
      end
      chk({nm, " latency"}, n, 45);
      chk({nm, " y"}, y, ey);
      chk({nm, " zero_w"}, zero_w, ezw);
      if (out_ready) begin
         @(posedge clk); #1;
         chk({nm, " release"}, {out_valid, in_ready}, 2'b01);
      end
   endtask

   initial begin : main
      vec_t tv [9];
      logic signed [15:0] ey;
      logic ezw;
      wset_t rw;
      int errs;

      tv[0] = '{wv(4, 16'hFFFF, -1, 0), 16'sd0, 1'b0, "center"};
      tv[1] = '{wv(0, 16'hFFFF, -1, 0), -16'sd20000, 1'b0, "corner00"};
      tv[2] = '{wv(0, 16'h4000, 8, 16'hC000), 16'sd10000, 1'b0, "blend"};
      tv[3] = '{wv(0, 16'hC000, 8, 16'h4000), -16'sd10000, 1'b0, "blend_sw"};
      tv[4] = '{wv(0, 16'd1, 1, 16'd2), -16'sd13333, 1'b0, "trunc_neg"};
      tv[5] = '{wv(8, 16'd1, 7, 16'd2), 16'sd13333, 1'b0, "trunc_pos"};
      tv[6] = '{wv(-1, 0, -1, 0), 16'sd0, 1'b1, "all_zero"};
      tv[7] = '{wv(5, 16'h0100, -1, 0), 16'sd10000, 1'b0, "after_zero"};
      tv[8] = '{wset_t'('1), 16'sd0, 1'b0, "full_scale"};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      set_w('0);
      repeat (3) @(posedge clk);
      #1;
      chk("rst in_ready", in_ready, 1);
      chk("rst out_valid", out_valid, 0);
      chk("rst y", y, 0);
      chk("rst zero_w", zero_w, 0);
      chk("rst busy", busy, 0);
      rst = 1'b0;

      for (int i = 0; i < 9; i++) do_op(tv[i].w, tv[i].y, tv[i].zw, tv[i].nm);

      // backpressure: result must hold while new requests are ignored
      out_ready = 1'b0;
      do_op(tv[2].w, tv[2].y, tv[2].zw, "bp");
      errs = 0;
      for (int c = 0; c < 20; c++) begin
         in_valid = 1'b1;
         set_w(wset_t'({$urandom, $urandom, $urandom, $urandom, $urandom}));
         @(posedge clk); #1;
         if (y != 16'sd10000 || !out_valid || in_ready || zero_w) errs++;
      end
      chk("bp hold_errs", errs, 0);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp release", {out_valid, in_ready}, 2'b01);
      do_op(tv[8].w, tv[8].y, tv[8].zw, "bp_next");

      // reset during the divide
      do_op(tv[1].w, tv[1].y, tv[1].zw, "pre_rst");
      set_w(tv[2].w);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (29) @(posedge clk);
      #1;
      chk("mid busy", busy, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("mid_rst state", {out_valid, in_ready, busy, zero_w}, 4'b0100);
      chk("mid_rst y", y, 0);
      rst = 1'b0;
      do_op(tv[3].w, tv[3].y, tv[3].zw, "post_rst");

      for (int i = 0; i < 40; i++) begin
         for (int k = 0; k < 9; k++)
            rw[k] = ($urandom_range(0, 2) == 0 || i % 10 == 0) ? 16'h0 : 16'($urandom);
         model(rw, ey, ezw);
         do_op(rw, ey, ezw, $sformatf("rand%0d", i));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
